// File: rtl/pipe_ctrl_if.sv
// Front-end control bundle between execute/memory stages and the PC/IF-ID sequencer.
// Optional interrupt signals exist only when PIPE_CTRL_IRQ_EN is defined.
interface pipe_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ex_jump_en_i;
  logic [ADDR_W-1:0] ex_jump_addr_i;
  logic              ex_hold_i;
  logic              mem_hold_i;
  logic              hold_flag_o;
  logic              jump_en_o;
  logic [ADDR_W-1:0] jump_addr_o;
  logic              flush_o;
`ifdef PIPE_CTRL_IRQ_EN
  logic              irq_req_i;
  logic [ADDR_W-1:0] irq_vec_i;
  logic [ADDR_W-1:0] pc_i;
  logic              irq_ack_o;
  logic [ADDR_W-1:0] epc_o;
`endif

  modport master (
    output ex_jump_en_i, ex_jump_addr_i, ex_hold_i, mem_hold_i,
`ifdef PIPE_CTRL_IRQ_EN
    output irq_req_i, irq_vec_i, pc_i,
    input  irq_ack_o, epc_o,
`endif
    input  hold_flag_o, jump_en_o, jump_addr_o, flush_o
  );

  modport slave (
    input  ex_jump_en_i, ex_jump_addr_i, ex_hold_i, mem_hold_i,
`ifdef PIPE_CTRL_IRQ_EN
    input  irq_req_i, irq_vec_i, pc_i,
    output irq_ack_o, epc_o,
`endif
    output hold_flag_o, jump_en_o, jump_addr_o, flush_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// PC / IF-ID sequencing controller: merges redirects and holds, inserts flush bubbles.
// Optional interrupt entry is enabled by defining PIPE_CTRL_IRQ_EN.
module pipe_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_addr;
  logic [3:0]        flush_cnt;
  logic              in_redirect;

  assign in_redirect     = (state == REDIRECT);
  // Hold is combinational so a stall freezes the PC in the cycle it is raised.
  assign bus.hold_flag_o = bus.ex_hold_i | bus.mem_hold_i | in_redirect;
  assign bus.jump_en_o   = in_redirect & ~bus.mem_hold_i;
  assign bus.flush_o     = (state != RUN);
  assign bus.jump_addr_o = pend_addr;

`ifdef PIPE_CTRL_IRQ_EN
  logic              irq_taken;
  logic [ADDR_W-1:0] epc;
  logic              irq_accept;

  assign irq_accept    = bus.irq_req_i & ~bus.ex_hold_i & ~bus.mem_hold_i;
  assign bus.irq_ack_o = bus.jump_en_o & irq_taken;
  assign bus.epc_o     = epc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pend_addr <= '0;
      flush_cnt <= '0;
`ifdef PIPE_CTRL_IRQ_EN
      irq_taken <= 1'b0;
      epc       <= '0;
`endif
    end else begin
      case (state)
        RUN: begin
          if (bus.ex_jump_en_i) begin
            pend_addr <= bus.ex_jump_addr_i;
            state     <= REDIRECT;
`ifdef PIPE_CTRL_IRQ_EN
            irq_taken <= 1'b0;
          end else if (irq_accept) begin
            pend_addr <= bus.irq_vec_i;
            epc       <= bus.pc_i;
            irq_taken <= 1'b1;
            state     <= REDIRECT;
`endif
          end
        end
        REDIRECT: begin
          // Younger redirects arriving here are wrong-path and dropped.
          if (!bus.mem_hold_i) begin
            if (FLUSH_CYCLES == 0) begin
              state <= RUN;
            end else begin
              state     <= FLUSH;
              flush_cnt <= 4'(FLUSH_CYCLES);
            end
          end
        end
        FLUSH: begin
          if (!bus.mem_hold_i) begin
            if (flush_cnt == 4'd1) begin
              state     <= RUN;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt - 4'd1;
            end
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal sequences plus randomized traffic checked
// every cycle against a bubble-counting model of the controller.
module tb_pipe_ctrl;
  localparam int AW = 32;
  localparam int FC = 2;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  pipe_ctrl_if #(.ADDR_W(AW)) bus ();

  pipe_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A redirect is "outstanding" until issued; then FC bubbles drain while memory is ready.
  bit              m_valid = 0;
  bit              m_out;
  int              m_bub;
  logic [AW-1:0]   m_addr;
  bit              m_irq;
  logic [AW-1:0]   m_epc;

  always @(negedge clk) begin
    logic exp_hold, exp_jump, exp_flush;
    exp_hold  = bus.ex_hold_i | bus.mem_hold_i | m_out;
    exp_jump  = m_out & ~bus.mem_hold_i;
    exp_flush = m_out || (m_bub > 0);
    if (m_valid) begin
      chk("m_hold",  AW'(bus.hold_flag_o), AW'(exp_hold));
      chk("m_jump",  AW'(bus.jump_en_o),   AW'(exp_jump));
      chk("m_flush", AW'(bus.flush_o),     AW'(exp_flush));
      chk("m_addr",  bus.jump_addr_o,      m_addr);
`ifdef PIPE_CTRL_IRQ_EN
      chk("m_ack",   AW'(bus.irq_ack_o),   AW'(exp_jump & m_irq));
      chk("m_epc",   bus.epc_o,            m_epc);
`endif
    end
    if (rst) begin
      m_valid = 1; m_out = 0; m_bub = 0; m_addr = '0; m_irq = 0; m_epc = '0;
    end else if (m_out) begin
      if (!bus.mem_hold_i) begin m_out = 0; m_bub = FC; end
    end else if (m_bub > 0) begin
      if (!bus.mem_hold_i) m_bub--;
    end else if (bus.ex_jump_en_i) begin
      m_addr = bus.ex_jump_addr_i; m_out = 1; m_irq = 0;
`ifdef PIPE_CTRL_IRQ_EN
    end else if (bus.irq_req_i && !bus.ex_hold_i && !bus.mem_hold_i) begin
      m_addr = bus.irq_vec_i; m_epc = bus.pc_i; m_out = 1; m_irq = 1;
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic j, input logic [AW-1:0] a, input logic eh, input logic mh);
    bus.ex_jump_en_i   = j;
    bus.ex_jump_addr_i = a;
    bus.ex_hold_i      = eh;
    bus.mem_hold_i     = mh;
    #2;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string nm, input logic h, input logic j, input logic f,
                      input logic [AW-1:0] a);
    chk({nm, "_hold"},  AW'(bus.hold_flag_o), AW'(h));
    chk({nm, "_jump"},  AW'(bus.jump_en_o),   AW'(j));
    chk({nm, "_flush"}, AW'(bus.flush_o),     AW'(f));
    chk({nm, "_addr"},  bus.jump_addr_o,      a);
  endtask

  initial begin
    rst = 1'b1;
    bus.ex_jump_en_i = 1'b0; bus.ex_jump_addr_i = '0;
    bus.ex_hold_i = 1'b0;    bus.mem_hold_i = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
    bus.irq_req_i = 1'b0; bus.irq_vec_i = '0; bus.pc_i = '0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      drive(0, '0, 0, 0); outs("idle", 0, 0, 0, 32'h0); next();
    end

    // single redirect
    drive(1, 32'h100, 0, 0); outs("j1_n", 0, 0, 0, 32'h0); next();
    drive(0, '0, 0, 0); outs("j1_n1", 1, 1, 1, 32'h100); next();
    drive(0, '0, 0, 0); outs("j1_n2", 0, 0, 1, 32'h100); next();
    drive(0, '0, 0, 0); outs("j1_n3", 0, 0, 1, 32'h100); next();
    drive(0, '0, 0, 0); outs("j1_n4", 0, 0, 0, 32'h100); next();

    // redirect stalled by memory
    drive(1, 32'h200, 0, 0); next();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 0, 1); outs("j2_stall", 1, 0, 1, 32'h200); next();
    end
    drive(0, '0, 0, 0); outs("j2_go", 1, 1, 1, 32'h200); next();
    drive(0, '0, 0, 0); outs("j2_f1", 0, 0, 1, 32'h200); next();
    drive(0, '0, 0, 0); outs("j2_f2", 0, 0, 1, 32'h200); next();
    drive(0, '0, 0, 0); outs("j2_run", 0, 0, 0, 32'h200); next();

    // younger redirects are wrong-path
    drive(1, 32'h300, 0, 0); next();
    drive(1, 32'h400, 0, 0); outs("j3_n1", 1, 1, 1, 32'h300); next();
    drive(1, 32'h400, 0, 0); outs("j3_n2", 0, 0, 1, 32'h300); next();
    drive(0, '0, 0, 0); outs("j3_n3", 0, 0, 1, 32'h300); next();
    drive(0, '0, 0, 0); outs("j3_n4", 0, 0, 0, 32'h300); next();

    // execute hold only
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 0); outs("exh", 1, 0, 0, 32'h300); next();
    end
    drive(0, '0, 0, 0); outs("exh_end", 0, 0, 0, 32'h300); next();

    // reset mid-flush discards the redirect
    drive(1, 32'h600, 0, 0); next();
    drive(0, '0, 0, 0); next();
    rst = 1'b1; drive(0, '0, 0, 0); next();
    rst = 1'b0; drive(0, '0, 0, 0); outs("rst_mid", 0, 0, 0, 32'h0); next();

`ifdef PIPE_CTRL_IRQ_EN
    bus.irq_req_i = 1; bus.irq_vec_i = 32'h80; bus.pc_i = 32'h44;
    drive(0, '0, 0, 0); next();
    bus.irq_req_i = 0;
    drive(0, '0, 0, 0); outs("irq1", 1, 1, 1, 32'h80);
    chk("irq1_ack", AW'(bus.irq_ack_o), 32'h1); chk("irq1_epc", bus.epc_o, 32'h44); next();
    drive(0, '0, 0, 0); next();
    drive(0, '0, 0, 0); next();
    bus.irq_req_i = 1; bus.pc_i = 32'h48;
    drive(1, 32'h500, 0, 0); next();
    drive(0, '0, 0, 0); outs("irq2_j", 1, 1, 1, 32'h500);
    chk("irq2_noack", AW'(bus.irq_ack_o), 32'h0); next();
    drive(0, '0, 0, 0); next();
    drive(0, '0, 0, 0); next();
    drive(0, '0, 0, 0); outs("irq2_run", 0, 0, 0, 32'h500); next();
    bus.irq_req_i = 0;
    drive(0, '0, 0, 0); outs("irq2_i", 1, 1, 1, 32'h80);
    chk("irq2_ack", AW'(bus.irq_ack_o), 32'h1); chk("irq2_epc", bus.epc_o, 32'h48); next();
`endif

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
`ifdef PIPE_CTRL_IRQ_EN
      bus.irq_req_i = ($urandom_range(0, 9) < 2);
      bus.irq_vec_i = $urandom;
      bus.pc_i      = $urandom;
`endif
      drive(($urandom_range(0, 4) == 0), $urandom,
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
      next();
    end
    rst = 1'b0;
    drive(0, '0, 0, 0); next();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Front-end sequencing controller for the PC register and the IF/ID pipeline registers.
- Merges three sources into one control set: execute-stage redirect requests, multi-cycle execute holds and memory/bus wait holds.
- Produces hold_flag_o, jump_en_o, jump_addr_o and flush_o.
- Enforces the PC register's rule that a jump is accepted only while hold is asserted.
- Inserts a fixed number of flush bubbles after every redirect.

Parameters:
- ADDR_W, 32, PC/jump address width.
- FLUSH_CYCLES, 2, flush cycles after the redirect cycle (0..15; 0 = no FLUSH state).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_jump_en_i  in  1  execute stage requests a redirect this cycle.
- ex_jump_addr_i  in  ADDR_W  redirect target, valid with ex_jump_en_i.
- ex_hold_i  in  1  multi-cycle execute op busy (div/mul).
- mem_hold_i  in  1  load/store bus not ready.
- hold_flag_o  out  1  freeze PC; PC loads jump_addr_o when jump_en_o=1.
- jump_en_o  out  1  redirect PC this cycle.
- jump_addr_o  out  ADDR_W  redirect target.
- flush_o  out  1  kill IF/ID contents (insert NOP).

Behaviour:
- Reset (rst=1 at an edge): state=RUN, pending address=0, flush counter=0. All outputs 0 in the following cycle. Reset mid-redirect or mid-flush discards the redirect.
- FSM states: RUN, REDIRECT, FLUSH.
- hold_flag_o is combinational: ex_hold_i | mem_hold_i | (state==REDIRECT). A hold therefore freezes the PC in the same cycle it is raised.
- RUN:
  - ex_jump_en_i=1: latch ex_jump_addr_i into the pending register; next state REDIRECT. This is 1-cycle latency; the PC may advance once more, and that fetch is flushed.
  - The jump is accepted even while ex_hold_i or mem_hold_i is high.
- REDIRECT:
  - hold_flag_o=1, flush_o=1, jump_addr_o=pending address.
  - jump_en_o = !mem_hold_i. While mem_hold_i=1, remain in REDIRECT with jump_en_o=0.
  - On the cycle jump_en_o=1: next state is FLUSH with counter=FLUSH_CYCLES, or RUN if FLUSH_CYCLES=0.
  - ex_jump_en_i in REDIRECT is ignored: the oldest redirect wins and younger ones are wrong-path.
- FLUSH:
  - flush_o=1, jump_en_o=0.
  - Counter decrements on each cycle where mem_hold_i=0 and freezes while mem_hold_i=1.
  - At counter==1 with no mem hold, next state is RUN.
  - ex_jump_en_i is ignored (wrong-path).
- jump_addr_o holds the pending register value in every state. It is 0 after reset.
- Invariant: jump_en_o=1 implies hold_flag_o=1.
- Invariant: jump_en_o is high for exactly one cycle per accepted redirect.
- Simultaneous ex_jump_en_i and ex_hold_i in RUN: the hold is honoured now and the jump is taken in REDIRECT next cycle.

Optional Feature:
- Macro: PIPE_CTRL_IRQ_EN.
- When defined, add these ports:
  - irq_req_i in 1: level interrupt request.
  - irq_vec_i in ADDR_W: handler address.
  - pc_i in ADDR_W: current PC.
  - irq_ack_o out 1: acknowledge pulse.
  - epc_o out ADDR_W: saved PC.
- IRQ acceptance:
  - In RUN with irq_req_i=1, ex_jump_en_i=0, ex_hold_i=0 and mem_hold_i=0, the controller latches irq_vec_i as the pending address and pc_i into epc_o, then enters REDIRECT.
  - irq_ack_o=1 on the cycle jump_en_o=1 for that redirect.
- Priority: ex_jump_en_i beats irq_req_i in the same cycle. The IRQ is re-evaluated once the controller is back in RUN.
- epc_o resets to 0.
- When the macro is undefined, these ports and their logic are absent; behaviour is as above.

Test Plan:
- Reset then idle, all requests 0 for 5 cycles -> hold_flag_o=jump_en_o=flush_o=0 throughout; jump_addr_o=0.
- ex_jump_en_i=1, addr 0x100 for 1 cycle at cycle N (FLUSH_CYCLES=2):
  - cycle N+1: hold_flag_o=1, jump_en_o=1, flush_o=1, jump_addr_o=0x100.
  - cycles N+2 and N+3: flush_o=1, hold_flag_o=0.
  - cycle N+4: RUN, all outputs 0.
- Jump 0x200 at N with mem_hold_i=1 during N+1..N+3 -> jump_en_o=0 for N+1..N+3 and 1 at N+4; hold_flag_o=1 for N+1..N+4; single jump pulse.
- Jump 0x300 at N and second jump 0x400 at N+1 and N+2 -> exactly one jump_en_o pulse, jump_addr_o=0x300; 0x400 is never issued.
- ex_hold_i=1 for 4 cycles in RUN, no jump -> hold_flag_o=1 in those same 4 cycles, jump_en_o=flush_o=0, RUN retained.
- With PIPE_CTRL_IRQ_EN: irq_req_i=1, irq_vec_i=0x80, pc_i=0x44 in RUN -> next cycle jump_en_o=1, jump_addr_o=0x80, irq_ack_o=1, epc_o=0x44. Repeated with ex_jump_en_i=1 (0x500) in the same cycle -> 0x500 is issued first; the IRQ is taken after the flush completes.
